// File: rtl/sevenseg_scan_reader.sv
// rtl/sevenseg_scan_reader.sv - snoops a scanned 4-digit active-low seven-segment bus
// and rebuilds the hex digits, dots and glyph validity.
module sevenseg_scan_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] an,
   input  logic [0:6] seg,
   input  logic       dp,
   output logic [3:0] A,
   output logic [3:0] B,
   output logic [3:0] C,
   output logic [3:0] D,
   output logic [0:3] dots,
   output logic [0:3] digit_valid,
   output logic       frame_done,
   output logic       anode_err,
   output logic       seg_err
);
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [3:0] s_an;
   logic [0:6] s_seg;
   logic       s_dp;
   logic [7:0] cnt;
   logic [7:0] cnt_next;
   logic       changed;
   logic       cap;
   logic       cap_next;
   logic       single;
   logic [1:0] idx;
   logic [4:0] glyph;
   logic [0:3] seen;
   logic [0:3] seen_set;

   // Returns {legal, value}; seg[0] (segment a) is the MSB of the pattern.
   function automatic logic [4:0] decode(input logic [0:6] s);
      case (s)
         7'b0000001: decode = 5'h10;
         7'b1001111: decode = 5'h11;
         7'b0010010: decode = 5'h12;
         7'b0000110: decode = 5'h13;
         7'b1001100: decode = 5'h14;
         7'b0100100: decode = 5'h15;
         7'b0100000: decode = 5'h16;
         7'b0001111: decode = 5'h17;
         7'b0000000: decode = 5'h18;
         7'b0000100: decode = 5'h19;
         7'b0001000: decode = 5'h1A;
         7'b1100000: decode = 5'h1B;
         7'b0110001: decode = 5'h1C;
         7'b1000010: decode = 5'h1D;
         7'b0110000: decode = 5'h1E;
         7'b0111000: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

   always_comb begin
      changed  = ({an, seg, dp} != {s_an, s_seg, s_dp});
      cnt_next = cnt;
      if (changed)
         cnt_next = 8'd1;
      else if (cnt >= STABLE)
         cnt_next = STABLE;
      else
         cnt_next = cnt + 8'd1;
      // Strobe only on the transition into the stable count, never while held.
      cap_next = (cnt_next == STABLE) && (changed || cnt != STABLE);

      single = 1'b1;
      idx    = 2'd0;
      case (s_an)
         4'b0111: idx = 2'd0;
         4'b1011: idx = 2'd1;
         4'b1101: idx = 2'd2;
         4'b1110: idx = 2'd3;
         default: single = 1'b0;
      endcase
      glyph    = decode(s_seg);
      seen_set = seen | (single ? (4'b1000 >> idx) : 4'b0000);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_an        <= 4'b1111;
         s_seg       <= 7'h7F;
         s_dp        <= 1'b1;
         cnt         <= 8'd0;
         cap         <= 1'b0;
         seen        <= 4'b0000;
         A           <= 4'h0;
         B           <= 4'h0;
         C           <= 4'h0;
         D           <= 4'h0;
         dots        <= 4'b0000;
         digit_valid <= 4'b0000;
         frame_done  <= 1'b0;
         anode_err   <= 1'b0;
         seg_err     <= 1'b0;
      end else begin
         s_an       <= an;
         s_seg      <= seg;
         s_dp       <= dp;
         cnt        <= cnt_next;
         cap        <= cap_next;
         frame_done <= 1'b0;
         anode_err  <= 1'b0;
         seg_err    <= 1'b0;
         if (cap && single) begin
            dots[idx]        <= ~s_dp;
            digit_valid[idx] <= glyph[4];
            seg_err          <= ~glyph[4];
            if (glyph[4]) begin
               case (idx)
                  2'd0: A <= glyph[3:0];
                  2'd1: B <= glyph[3:0];
                  2'd2: C <= glyph[3:0];
                  2'd3: D <= glyph[3:0];
               endcase
            end
            if (seen_set == 4'b1111) begin
               frame_done <= 1'b1;
               seen       <= 4'b0000;
            end else begin
               seen <= seen_set;
            end
         end else if (cap && s_an != 4'b1111) begin
            anode_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// tb/tb_sevenseg_scan_reader.sv - scoreboard bench for sevenseg_scan_reader
module tb_sevenseg_scan_reader;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] an  = 4'b1111;
   logic [0:6] seg = 7'h7F;
   logic       dp  = 1'b1;
   logic [3:0] A, B, C, D;
   logic [0:3] dots, digit_valid;
   logic       frame_done, anode_err, seg_err;

   sevenseg_scan_reader #(.STABLE_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
      .A(A), .B(B), .C(C), .D(D), .dots(dots), .digit_valid(digit_valid),
      .frame_done(frame_done), .anode_err(anode_err), .seg_err(seg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected pulse events: mask = {frame_done, anode_err, seg_err}
   typedef struct {
      logic [2:0] mask;
      int         at;
   } ev_t;
   ev_t sb[$];

   logic [0:6] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic [3:0]  m_val  [4];
   logic        m_dot  [4];
   logic        m_vld  [4];
   logic        m_seen [4];
   logic [11:0] prev;

   ev_t        mon_e;
   logic [2:0] mon_m;
   always @(negedge clk) begin
      mon_m = {frame_done, anode_err, seg_err};
      if (mon_m != 3'b000) begin
         if (sb.size() == 0) begin
            check("spurious_pulse", 32'(mon_m), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_at", cyc, mon_e.at);
            check("pulse_kind", 32'(mon_m), 32'(mon_e.mask));
         end
      end
   end

   function automatic logic [3:0] an_of(input int i);
      return 4'b1111 ^ (4'b1000 >> i);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 4'h0; m_dot[i] = 1'b0; m_vld[i] = 1'b0; m_seen[i] = 1'b0;
      end
      prev = {4'b1111, 7'h7F, 1'b1};
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_A"}, 32'(A), 32'(m_val[0]));
      check({tag, "_B"}, 32'(B), 32'(m_val[1]));
      check({tag, "_C"}, 32'(C), 32'(m_val[2]));
      check({tag, "_D"}, 32'(D), 32'(m_val[3]));
      check({tag, "_dots"}, 32'(dots), 32'({m_dot[0], m_dot[1], m_dot[2], m_dot[3]}));
      check({tag, "_valid"}, 32'(digit_valid), 32'({m_vld[0], m_vld[1], m_vld[2], m_vld[3]}));
   endtask

   task automatic step(input logic [3:0] a, input logic [0:6] s, input logic d,
                       input int hold, input bit chk, input string tag);
      logic [11:0] st;
      logic [2:0]  m;
      logic [3:0]  gval;
      bit          chg, gv;
      int          idx;
      st   = {a, s, d};
      chg  = (st != prev);
      prev = st;
      an = a; seg = s; dp = d;
      m = 3'b000;
      if (chg && hold >= N && a != 4'b1111) begin
         idx = -1;
         for (int i = 0; i < 4; i++) if (a == an_of(i)) idx = i;
         if (idx < 0) begin
            m[1] = 1'b1;
         end else begin
            m_dot[idx] = ~d;
            gv = 1'b0; gval = 4'h0;
            for (int g = 0; g < 16; g++) if (glyph_tab[g] == s) begin gv = 1'b1; gval = g[3:0]; end
            if (gv) m_val[idx] = gval;
            m_vld[idx]  = gv;
            m[0]        = ~gv;
            m_seen[idx] = 1'b1;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
               m[2] = 1'b1;
               for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
            end
         end
         if (m != 3'b000) sb.push_back('{m, cyc + 1 + N});
      end
      repeat (hold) @(negedge clk);
      if (chk) check_outputs(tag);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; an = 4'b1111; seg = 7'h7F; dp = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   logic [3:0] t2_vals [4] = '{4'h1, 4'h2, 4'hE, 4'hF};
   logic [3:0] t6_vals [4] = '{4'h9, 4'h8, 4'hB, 4'h0};
   logic       t6_dots [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      @(negedge clk);
      do_reset(3);
      check_outputs("reset");
      check("reset_pulses", 32'({frame_done, anode_err, seg_err}), 32'd0);

      // 1: single digit A=3 with dot, exact update latency
      step(4'b0111, 7'b0000110, 1'b0, N, 1'b0, "t1");
      check("t1_not_yet", 32'(A), 32'h0);
      @(negedge clk);
      check("t1_A", 32'(A), 32'h3);
      check("t1_dot", 32'(dots[0]), 32'd1);
      check("t1_valid", 32'(digit_valid[0]), 32'd1);
      step(4'b0111, 7'b0000110, 1'b0, 5, 1'b1, "t1_hold");

      // 2: two full scans 1,2,E,F
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++)
            step(an_of(i), glyph_tab[t2_vals[i]], 1'b1, 8, 1'b1, "t2");

      // 3: short hold on B ignored, then blank segments give seg_err
      step(4'b1011, glyph_tab[8], 1'b1, 3, 1'b0, "t3_short");
      step(4'b1011, 7'h7F, 1'b1, 6, 1'b1, "t3_blank");

      // 4: two anodes low, then idle
      step(4'b0011, 7'b0000000, 1'b1, 6, 1'b1, "t4_multi");
      step(4'b1111, 7'h7F, 1'b1, 6, 1'b1, "t4_idle");

      // 5: reset mid-frame discards progress
      step(an_of(0), glyph_tab[5], 1'b1, 6, 1'b1, "t5_pre");
      step(an_of(1), glyph_tab[6], 1'b1, 6, 1'b1, "t5_pre");
      do_reset(1);
      check_outputs("t5_reset");
      step(an_of(2), glyph_tab[7], 1'b1, 6, 1'b1, "t5_post");
      step(an_of(3), glyph_tab[10], 1'b1, 6, 1'b1, "t5_post");
      step(an_of(0), glyph_tab[12], 1'b0, 6, 1'b1, "t5_post");
      step(an_of(1), glyph_tab[13], 1'b1, 6, 1'b1, "t5_post");

      // 6: display-driver style refresh with blanking between digits
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++) begin
            step(an_of(i), glyph_tab[t6_vals[i]], ~t6_dots[i], 12, 1'b1, "t6");
            step(4'b1111, 7'h7F, 1'b1, 2, 1'b0, "t6_blank");
         end
      repeat (10) @(negedge clk);
      check("t6_valid_all", 32'(digit_valid), 32'hF);
      check("t6_dots", 32'(dots), 32'b0101);
      check("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
